// File: rtl/cordic_mem_pkg.sv
// Shared constants and types for the CORDIC result memory writer.
//   DATA_W    : stream / memory data width
//   ADDR_W    : memory word-address width
//   MEM_DEPTH : number of valid memory words (0..MEM_DEPTH-1)
//   BE_ALL    : byte-enable value used on every write
//   state_t   : run controller states
package cordic_mem_pkg;

    localparam int DATA_W    = 32;
    localparam int ADDR_W    = 13;
    localparam int MEM_DEPTH = 6050;
    localparam int BE_W      = DATA_W / 8;

    localparam logic [BE_W-1:0] BE_ALL = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_DRAIN,
        ST_DONE
    } state_t;

endpackage

// File: rtl/sync_fifo.sv
// Small show-ahead synchronous FIFO.
//   clk, rst_n : clock, asynchronous active-low reset
//   push, din  : write side (ignored when full)
//   pop        : read side, consumes dout (ignored when empty)
//   flush      : empties the FIFO; wins over a same-cycle push/pop
//   full/empty : status derived from registered pointers only
//   dout       : head entry, valid whenever empty=0
module sync_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic             full,
    output logic             empty,
    output logic [WIDTH-1:0] dout
);

    localparam int PTR_W = $clog2(DEPTH);

    // One extra pointer bit distinguishes full from empty.
    logic [PTR_W:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]   rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign dout  = mem[rd_ptr_q[PTR_W-1:0]];

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + (PTR_W+1)'(1);
            if (do_pop)  rd_ptr_d = rd_ptr_q + (PTR_W+1)'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage carries no reset; entries are only read after being written.
    always_ff @(posedge clk) begin
        if (do_push && !flush) mem[wr_ptr_q[PTR_W-1:0]] <= din;
    end

endmodule

// File: rtl/cordic_result_mem_writer.sv
// Buffers CORDIC result words from a valid/ready stream and writes them to
// consecutive word addresses of a single-port on-chip memory.
//   start/base_addr/word_count/wrap_en : arm a run (ignored while busy)
//   abort                              : cancel run, flush buffer, no done
//   hold                               : suppress memory writes; buffer fills
//   s_valid/s_data/s_ready             : input stream
//   m_*                                : registered memory slave signals
//   busy/done/overflow_err/words_written : run status
module cordic_result_mem_writer
    import cordic_mem_pkg::*;
#(
    parameter int DATA_W     = cordic_mem_pkg::DATA_W,
    parameter int ADDR_W     = cordic_mem_pkg::ADDR_W,
    parameter int MEM_DEPTH  = cordic_mem_pkg::MEM_DEPTH,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                start,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W-1:0]   word_count,
    input  logic                wrap_en,
    input  logic                abort,
    input  logic                hold,
    input  logic                s_valid,
    input  logic [DATA_W-1:0]   s_data,
    output logic                s_ready,
    output logic [ADDR_W-1:0]   m_address,
    output logic [DATA_W/8-1:0] m_byteenable,
    output logic                m_chipselect,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    output logic                m_clken,
    output logic                busy,
    output logic                done,
    output logic                overflow_err,
    output logic [ADDR_W-1:0]   words_written
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);
    localparam logic [ADDR_W:0]   DEPTH_EXT = (ADDR_W+1)'(MEM_DEPTH);
    localparam logic [ADDR_W-1:0] ONE       = ADDR_W'(1);

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
    logic [ADDR_W-1:0]   count_q, count_d;
    logic                wrap_q, wrap_d;
    logic [ADDR_W-1:0]   accepted_q, accepted_d;
    logic [ADDR_W-1:0]   accept_lim_q, accept_lim_d;
    logic [ADDR_W-1:0]   words_written_q, words_written_d;
    logic                overflow_q, overflow_d;
    logic [ADDR_W-1:0]   m_addr_q, m_addr_d;
    logic [DATA_W-1:0]   m_data_q, m_data_d;
    logic [DATA_W/8-1:0] m_be_q, m_be_d;
    logic                m_wr_q, m_wr_d;
    logic                m_clken_q;

    logic                fifo_push, fifo_pop, fifo_flush;
    logic                fifo_full, fifo_empty;
    logic [DATA_W-1:0]   fifo_dout;
    logic                s_ready_int;
    logic [ADDR_W:0]     room;

    sync_fifo #(
        .WIDTH (DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset_n),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .flush (fifo_flush),
        .din   (s_data),
        .full  (fifo_full),
        .empty (fifo_empty),
        .dout  (fifo_dout)
    );

    // Acceptance is capped at accept_lim: without wrap we never take words
    // that would land beyond the top of memory, so they stay upstream.
    assign s_ready_int = (state_q == ST_RUN) && !fifo_full && !abort &&
                         (accepted_q < accept_lim_q);

    always_comb begin
        state_d         = state_q;
        cur_addr_d      = cur_addr_q;
        count_d         = count_q;
        wrap_d          = wrap_q;
        accepted_d      = accepted_q;
        accept_lim_d    = accept_lim_q;
        words_written_d = words_written_q;
        overflow_d      = overflow_q;
        m_addr_d        = m_addr_q;
        m_data_d        = m_data_q;
        m_be_d          = '0;
        m_wr_d          = 1'b0;
        fifo_pop        = 1'b0;
        fifo_flush      = 1'b0;
        fifo_push       = s_valid && s_ready_int;
        room            = DEPTH_EXT - {1'b0, base_addr};

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    count_d         = word_count;
                    wrap_d          = wrap_en;
                    cur_addr_d      = base_addr;
                    overflow_d      = 1'b0;
                    words_written_d = '0;
                    accepted_d      = '0;
                    if (!wrap_en && ({1'b0, word_count} > room))
                        accept_lim_d = room[ADDR_W-1:0];
                    else
                        accept_lim_d = word_count;
                    if ({1'b0, base_addr} >= DEPTH_EXT) begin
                        overflow_d = 1'b1;
                        state_d    = ST_DONE;
                    end else if (word_count == '0) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_RUN;
                    end
                end
            end

            ST_RUN, ST_DRAIN: begin
                if (fifo_push) begin
                    accepted_d = accepted_q + ONE;
                    if (accepted_q + ONE == count_q) state_d = ST_DRAIN;
                end
                if (!fifo_empty && !hold) begin
                    fifo_pop        = 1'b1;
                    m_wr_d          = 1'b1;
                    m_be_d          = '1;
                    m_addr_d        = cur_addr_q;
                    m_data_d        = fifo_dout;
                    words_written_d = words_written_q + ONE;
                    if (cur_addr_q == LAST_ADDR) begin
                        if (wrap_q) begin
                            cur_addr_d = '0;
                        end else begin
                            overflow_d = 1'b1;
                            fifo_flush = 1'b1;
                            state_d    = ST_DONE;
                        end
                    end else begin
                        cur_addr_d = cur_addr_q + ONE;
                    end
                end
                // In DRAIN nothing is pushed, so an empty buffer means the
                // final pop already happened on an earlier edge.
                if (state_q == ST_DRAIN && fifo_empty) state_d = ST_DONE;
            end

            ST_DONE: state_d = ST_IDLE;

            default: state_d = ST_IDLE;
        endcase

        // abort overrides everything decided above for this cycle.
        if (abort && state_q != ST_IDLE) begin
            state_d         = ST_IDLE;
            fifo_flush      = 1'b1;
            fifo_pop        = 1'b0;
            m_wr_d          = 1'b0;
            m_be_d          = '0;
            m_addr_d        = m_addr_q;
            m_data_d        = m_data_q;
            cur_addr_d      = cur_addr_q;
            words_written_d = words_written_q;
            overflow_d      = overflow_q;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= ST_IDLE;
            cur_addr_q      <= '0;
            count_q         <= '0;
            wrap_q          <= 1'b0;
            accepted_q      <= '0;
            accept_lim_q    <= '0;
            words_written_q <= '0;
            overflow_q      <= 1'b0;
            m_addr_q        <= '0;
            m_data_q        <= '0;
            m_be_q          <= '0;
            m_wr_q          <= 1'b0;
            m_clken_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            cur_addr_q      <= cur_addr_d;
            count_q         <= count_d;
            wrap_q          <= wrap_d;
            accepted_q      <= accepted_d;
            accept_lim_q    <= accept_lim_d;
            words_written_q <= words_written_d;
            overflow_q      <= overflow_d;
            m_addr_q        <= m_addr_d;
            m_data_q        <= m_data_d;
            m_be_q          <= m_be_d;
            m_wr_q          <= m_wr_d;
            m_clken_q       <= 1'b1;
        end
    end

    assign s_ready       = s_ready_int;
    assign m_address     = m_addr_q;
    assign m_writedata   = m_data_q;
    assign m_byteenable  = m_be_q;
    assign m_write       = m_wr_q;
    assign m_chipselect  = m_wr_q;
    assign m_clken       = m_clken_q;
    assign busy          = (state_q == ST_RUN) || (state_q == ST_DRAIN);
    assign done          = (state_q == ST_DONE);
    assign overflow_err  = overflow_q;
    assign words_written = words_written_q;

endmodule

// File: tb/tb_cordic_result_mem_writer.sv
module tb_cordic_result_mem_writer;

    localparam int MEM_DEPTH = 6050;

    typedef struct packed {
        logic [12:0] addr;
        logic [31:0] data;
    } exp_t;

    logic        clk;
    logic        reset_n;
    logic        start;
    logic [12:0] base_addr;
    logic [12:0] word_count;
    logic        wrap_en;
    logic        abort;
    logic        hold;
    logic        s_valid;
    logic [31:0] s_data;
    logic        s_ready;
    logic [12:0] m_address;
    logic [3:0]  m_byteenable;
    logic        m_chipselect;
    logic        m_write;
    logic [31:0] m_writedata;
    logic        m_clken;
    logic        busy;
    logic        done;
    logic        overflow_err;
    logic [12:0] words_written;

    cordic_result_mem_writer dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .start         (start),
        .base_addr     (base_addr),
        .word_count    (word_count),
        .wrap_en       (wrap_en),
        .abort         (abort),
        .hold          (hold),
        .s_valid       (s_valid),
        .s_data        (s_data),
        .s_ready       (s_ready),
        .m_address     (m_address),
        .m_byteenable  (m_byteenable),
        .m_chipselect  (m_chipselect),
        .m_write       (m_write),
        .m_writedata   (m_writedata),
        .m_clken       (m_clken),
        .busy          (busy),
        .done          (done),
        .overflow_err  (overflow_err),
        .words_written (words_written)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int          tests = 0;
    int          failed = 0;
    int          n_writes = 0;
    int          n_acc = 0;
    int          done_cnt = 0;
    int          cyc = 0;
    logic [12:0] model_addr = '0;
    exp_t        exp_q[$];
    logic [31:0] src_q[$];
    int          wr_cyc[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv) else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    function automatic logic [12:0] next_addr(input logic [12:0] a);
        return (a == 13'(MEM_DEPTH - 1)) ? 13'd0 : a + 13'd1;
    endfunction

    // Monitor: negedge sampling sees registered outputs from the previous
    // posedge and the handshake that the next posedge will complete.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (reset_n) begin
                if (m_write) begin
                    n_writes++;
                    wr_cyc.push_back(cyc);
                    tests++;
                    assert (exp_q.size() != 0) else begin
                        failed++;
                        $error("FAIL unexpected_write: observed write at %0h expected none", m_address);
                    end
                    if (exp_q.size() != 0) begin
                        e = exp_q.pop_front();
                        chk("wr_addr", 64'(m_address), 64'(e.addr));
                        chk("wr_data", 64'(m_writedata), 64'(e.data));
                        chk("wr_be", 64'(m_byteenable), 64'h0F);
                        chk("wr_cs", 64'(m_chipselect), 64'd1);
                    end
                end
                if (done) done_cnt++;
                if (s_valid && s_ready) begin
                    n_acc++;
                    exp_q.push_back('{addr: model_addr, data: s_data});
                    model_addr = next_addr(model_addr);
                end
            end
        end
    end

    // Stream source: drops words the monitor saw accepted, presents the next.
    initial begin
        int src_taken;
        src_taken = 0;
        s_valid = 1'b0;
        s_data  = '0;
        forever begin
            @(posedge clk);
            #1;
            while (src_taken < n_acc) begin
                if (src_q.size() != 0) void'(src_q.pop_front());
                src_taken++;
            end
            s_valid = (src_q.size() != 0);
            s_data  = (src_q.size() != 0) ? src_q[0] : 32'h0;
        end
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic load_words(input logic [31:0] first, input int n);
        for (int i = 0; i < n; i++) src_q.push_back(first + 32'(i));
    endtask

    task automatic start_run(input logic [12:0] b, input logic [12:0] c, input logic w);
        step(1);
        base_addr  = b;
        word_count = c;
        wrap_en    = w;
        model_addr = b;
        start      = 1'b1;
        step(1);
        start      = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int d0);
        for (int i = 0; i < 100 && done_cnt == d0; i++) step(1);
        chk({tag, "_done_seen"}, 64'(done_cnt > d0), 64'd1);
        step(3);
        chk({tag, "_done_once"}, 64'(done_cnt - d0), 64'd1);
    endtask

    initial begin
        int w0, a0, d0, seen;

        reset_n = 1'b0; start = 1'b0; base_addr = '0; word_count = '0;
        wrap_en = 1'b0; abort = 1'b0; hold = 1'b0;
        #1;
        chk("rst_clken", 64'(m_clken), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_sready", 64'(s_ready), 64'd0);
        chk("rst_mwrite", 64'(m_write), 64'd0);
        chk("rst_ww", 64'(words_written), 64'd0);
        #21 reset_n = 1'b1;
        step(1);
        chk("clken_after_rst", 64'(m_clken), 64'd1);

        // Basic run of 4 back-to-back words from address 0.
        load_words(32'hA0000000, 4);
        w0 = n_writes; d0 = done_cnt;
        start_run(13'd0, 13'd4, 1'b0);
        wait_done("basic", d0);
        chk("basic_writes", 64'(n_writes - w0), 64'd4);
        chk("basic_ww", 64'(words_written), 64'd4);
        chk("basic_ovf", 64'(overflow_err), 64'd0);
        chk("basic_busy", 64'(busy), 64'd0);
        chk("basic_sb", 64'(exp_q.size()), 64'd0);

        // Wrap at the top of memory.
        load_words(32'hB0000000, 4);
        w0 = n_writes; d0 = done_cnt;
        start_run(13'd6048, 13'd4, 1'b1);
        wait_done("wrap", d0);
        chk("wrap_writes", 64'(n_writes - w0), 64'd4);
        chk("wrap_ovf", 64'(overflow_err), 64'd0);
        chk("wrap_sb", 64'(exp_q.size()), 64'd0);

        // No wrap: only two words fit, the rest stay upstream.
        load_words(32'hC0000000, 4);
        w0 = n_writes; a0 = n_acc; d0 = done_cnt;
        start_run(13'd6048, 13'd4, 1'b0);
        wait_done("nowrap", d0);
        chk("nowrap_writes", 64'(n_writes - w0), 64'd2);
        chk("nowrap_acc", 64'(n_acc - a0), 64'd2);
        chk("nowrap_ovf", 64'(overflow_err), 64'd1);
        chk("nowrap_sready", 64'(s_ready), 64'd0);
        chk("nowrap_ww", 64'(words_written), 64'd2);
        chk("nowrap_sb", 64'(exp_q.size()), 64'd0);
        src_q.delete();
        step(2);

        // hold: buffer fills to 4, no writes until released.
        load_words(32'hD0000000, 6);
        hold = 1'b1;
        w0 = n_writes; a0 = n_acc; d0 = done_cnt;
        start_run(13'd100, 13'd6, 1'b0);
        chk("start_clears_ovf", 64'(overflow_err), 64'd0);
        step(12);
        chk("hold_acc", 64'(n_acc - a0), 64'd4);
        chk("hold_sready", 64'(s_ready), 64'd0);
        chk("hold_writes", 64'(n_writes - w0), 64'd0);
        chk("hold_busy", 64'(busy), 64'd1);
        wr_cyc.delete();
        hold = 1'b0;
        wait_done("hold", d0);
        chk("hold_total_writes", 64'(n_writes - w0), 64'd6);
        chk("hold_wrcnt", 64'(wr_cyc.size()), 64'd6);
        if (wr_cyc.size() >= 4) begin
            for (int i = 1; i < 4; i++)
                chk("hold_b2b", 64'(wr_cyc[i] - wr_cyc[i-1]), 64'd1);
        end
        chk("hold_sb", 64'(exp_q.size()), 64'd0);

        // abort after the second write.
        load_words(32'hE0000000, 8);
        w0 = n_writes; d0 = done_cnt; seen = 0;
        start_run(13'd200, 13'd8, 1'b0);
        for (int i = 0; i < 100 && seen < 2; i++) begin
            step(1);
            if (m_write) seen++;
        end
        chk("abort_reached_2", 64'(seen), 64'd2);
        abort = 1'b1;
        step(1);
        abort = 1'b0;
        chk("abort_mwrite", 64'(m_write), 64'd0);
        chk("abort_cs", 64'(m_chipselect), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_ww", 64'(words_written), 64'd2);
        step(5);
        chk("abort_no_done", 64'(done_cnt - d0), 64'd0);
        chk("abort_writes", 64'(n_writes - w0), 64'd2);
        src_q.delete();
        exp_q.delete();
        step(2);

        // Fresh run after abort must carry only new data.
        load_words(32'hF0000000, 2);
        w0 = n_writes; d0 = done_cnt;
        start_run(13'd300, 13'd2, 1'b0);
        wait_done("post_abort", d0);
        chk("post_abort_writes", 64'(n_writes - w0), 64'd2);
        chk("post_abort_ww", 64'(words_written), 64'd2);
        chk("post_abort_sb", 64'(exp_q.size()), 64'd0);

        // Asynchronous reset in the middle of a run.
        load_words(32'h12340000, 8);
        seen = 0;
        start_run(13'd400, 13'd8, 1'b0);
        for (int i = 0; i < 100 && seen == 0; i++) begin
            step(1);
            if (m_write) seen = 1;
        end
        chk("rst_run_active", 64'(seen), 64'd1);
        #2 reset_n = 1'b0;
        #1;
        chk("arst_mwrite", 64'(m_write), 64'd0);
        chk("arst_cs", 64'(m_chipselect), 64'd0);
        chk("arst_addr", 64'(m_address), 64'd0);
        chk("arst_data", 64'(m_writedata), 64'd0);
        chk("arst_be", 64'(m_byteenable), 64'd0);
        chk("arst_clken", 64'(m_clken), 64'd0);
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_sready", 64'(s_ready), 64'd0);
        chk("arst_ww", 64'(words_written), 64'd0);
        src_q.delete();
        exp_q.delete();
        #3 reset_n = 1'b1;
        step(1);
        chk("post_rst_clken", 64'(m_clken), 64'd1);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_done", 64'(done), 64'd0);
        chk("post_rst_mwrite", 64'(m_write), 64'd0);

        step(2);
        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/cordic_result_mem_writer.md
Name: cordic_result_mem_writer

Overview:
Upstream feeder for the 32-bit single-port on-chip memory. It takes CORDIC result words from a valid/ready stream and buffers them in a small FIFO. It then writes them to consecutive word addresses in the memory through the memory's native slave signals. A single start pulse arms a run of word_count writes beginning at base_addr, with optional wrap-around at the top of the memory.

Parameters:
DATA_W, 32, stream and memory data width
ADDR_W, 13, memory word-address width
MEM_DEPTH, 6050, number of valid memory words (addresses 0..MEM_DEPTH-1)
FIFO_DEPTH, 4, input buffer entries (power of two, >=2)

Ports:
clk  in  1  system clock; single clock domain
reset_n  in  1  asynchronous, active-low reset
start  in  1  one-cycle pulse; latches base_addr, word_count, wrap_en; ignored while busy
base_addr  in  ADDR_W  first word address of the run
word_count  in  ADDR_W  number of words to write (0 = empty run)
wrap_en  in  1  1: wrap address MEM_DEPTH-1 -> 0; 0: stop with overflow_err
abort  in  1  cancel the current run
hold  in  1  suppress memory writes (e.g. during memory freeze/reset_req); FIFO still fills
s_valid  in  1  stream word valid
s_data  in  DATA_W  stream word
s_ready  out  1  stream ready
m_address  out  ADDR_W  memory word address
m_byteenable  out  DATA_W/8  byte enables; all-ones on every write
m_chipselect  out  1  memory chipselect
m_write  out  1  memory write strobe
m_writedata  out  DATA_W  memory write data
m_clken  out  1  memory clock enable
busy  out  1  run in progress
done  out  1  one-cycle pulse at the normal end or the overflow end of a run
overflow_err  out  1  sticky; cleared by the next accepted start
words_written  out  ADDR_W  writes issued in the current/last run

Behaviour:
- Reset (async, reset_n low): all outputs 0, including m_clken. FIFO empty, state IDLE, counters 0. Outputs take their reset values immediately, without waiting for a clock edge.
- Out of reset, m_clken=1 constantly. All m_* outputs are registered.
- FSM states: IDLE, RUN, DRAIN, DONE.
  - IDLE + start: latch inputs, clear overflow_err and words_written, cur_addr=base_addr.
    - base_addr >= MEM_DEPTH: set overflow_err, go to DONE.
    - word_count == 0: go to DONE.
    - Otherwise: go to RUN.
  - RUN: s_ready = !fifo_full, evaluated on registered full, so there is no push-when-full even on a same-cycle pop. When accepted == word_count, go to DRAIN; s_ready=0 in DRAIN.
  - DRAIN: when the FIFO is empty and the last write has been issued, go to DONE.
  - DONE: done=1 for exactly one cycle, then IDLE. busy=1 in RUN and DRAIN only.
- Write issue (RUN/DRAIN): each cycle the FIFO is non-empty and hold=0, pop one word. On the next edge register m_chipselect=1, m_write=1, m_address=cur_addr, m_writedata=word, m_byteenable=all-ones. Otherwise m_chipselect=m_write=0.
- Throughput and latency: up to 1 write per cycle. The minimum latency is 2 edges from the acceptance edge to m_write being high.
- Address after each write:
  - cur_addr < MEM_DEPTH-1: cur_addr+1.
  - cur_addr == MEM_DEPTH-1 and wrap_en=1: wrap to 0.
  - cur_addr == MEM_DEPTH-1 and wrap_en=0: set overflow_err, flush the FIFO, drop the remaining words, set s_ready=0, go to DONE.
- words_written increments on each issued write and holds after DONE until the next start.
- hold=1: no pops, and m_write=0 on the next edge. The FIFO continues accepting until full.
- abort (any state except IDLE): flush the FIFO, force m_write/m_chipselect to 0 on the next edge, go to IDLE. No done pulse. words_written keeps its value. abort has priority over start and over any pending pop.
- start while busy is ignored, with no effect on the latched parameters.

Decomposition:
- Package cordic_mem_pkg:
  - Constants: ADDR_W, DATA_W, MEM_DEPTH.
  - State enum: IDLE/RUN/DRAIN/DONE.
  - Byte-enable all-ones constant.
- Sub-module sync_fifo:
  - Parameterised width/depth.
  - Signals: push, pop, flush, full, empty, dout (show-ahead).
  - Async active-low reset.

Test Plan:
- base=0, count=4, stream 0xA0000000..0xA0000003 back-to-back, hold=0 -> 4 consecutive writes at addr 0,1,2,3 with byteenable=0xF; one done pulse; words_written=4; overflow_err=0.
- base=6048, count=4, wrap_en=1 -> writes at 6048, 6049, 0, 1; overflow_err=0; done once.
- base=6048, count=4, wrap_en=0 -> writes at 6048, 6049 only; overflow_err=1; done; s_ready=0; 3rd/4th words not accepted.
- hold=1, count=6, push 6 words -> exactly 4 accepted, then s_ready=0 and no m_write. Release hold -> writes on 4 consecutive cycles, then the remaining 2; addresses contiguous; data in order.
- count=8, abort after the 2nd write -> no further m_write from the next edge; busy=0; no done pulse; words_written=2; FIFO empty; a new start succeeds.
- Run in progress, reset_n driven low between clock edges -> all outputs 0 immediately. After release, state is IDLE and m_clken=1 on the first clock.
